// File: rtl/data_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_pkg
// Description : Shared CPU memory geometry and word types for the datapath
//               and memory blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package data_ram_pkg;

    localparam int unsigned c_ADDR_W = 6;
    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_DEPTH  = 2 ** c_ADDR_W;

    typedef logic [c_ADDR_W-1:0] dm_addr_t;
    typedef logic [c_DATA_W-1:0] dm_data_t;

endpackage : data_ram_pkg
`default_nettype wire

// File: rtl/data_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_if
// Description : Data-memory access bus: write strobe, shared address, write
//               data and combinational read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_ram_if
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
);

    logic              Mem_Write;
    logic [ADDR_W-1:0] DM_Addr;
    logic [DATA_W-1:0] M_W_Data;
    logic [DATA_W-1:0] M_R_Data;

    modport master (
        output Mem_Write,
        output DM_Addr,
        output M_W_Data,
        input  M_R_Data
    );

    modport slave (
        input  Mem_Write,
        input  DM_Addr,
        input  M_W_Data,
        output M_R_Data
    );

endinterface : data_ram_if
`default_nettype wire

// File: rtl/data_ram_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_array
// Description : Flip-flop word array with a single write port, a whole-array
//               clear and every word exposed for an external read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_array
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              i_clear,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_mem [DEPTH]
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Clear wins over a coincident write so no word survives a reset.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (int'(i_addr) < DEPTH)) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_mem = r_mem;

endmodule : ram_array
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module      : data_ram
// Description : Word-addressed data memory, synchronous write, asynchronous
//               read, whole-array synchronous clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  wire logic   clk_dm,
    input  wire logic   rst_dm,
    data_ram_if.slave   bus
);

    logic [DATA_W-1:0] w_mem [DEPTH];
    logic [DATA_W-1:0] w_rdata;

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram_array (
        .clk     (clk_dm),
        .i_clear (rst_dm),
        .i_we    (bus.Mem_Write),
        .i_addr  (bus.DM_Addr),
        .i_wdata (bus.M_W_Data),
        .o_mem   (w_mem)
    );

    // Read straight from the array so a fresh write is visible right after its edge.
    always_comb begin
        w_rdata = '0;
        if (int'(bus.DM_Addr) < DEPTH) begin
            w_rdata = w_mem[bus.DM_Addr];
        end
    end

    assign bus.M_R_Data = w_rdata;

endmodule : data_ram
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram
// Description : Randomised self-checking bench for data_ram against an
//               array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram;

    logic clk_dm;
    logic rst_dm;

    data_ram_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    data_ram #(.ADDR_W(6), .DATA_W(32), .DEPTH(64)) dut (
        .clk_dm (clk_dm),
        .rst_dm (rst_dm),
        .bus    (bus)
    );

    initial clk_dm = 1'b0;
    always #5 clk_dm = ~clk_dm;

    logic [31:0] model [64];
    int          n_tests;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [5:0] addr, input logic [31:0] data);
        rst_dm        = rst;
        bus.Mem_Write = we;
        bus.DM_Addr   = addr;
        bus.M_W_Data  = data;
    endtask

    // Model update uses the values present at the edge, then settles 1 time unit.
    task automatic tick();
        @(posedge clk_dm);
        if (rst_dm) begin
            for (int i = 0; i < 64; i++) model[i] = 32'h0;
        end else if (bus.Mem_Write) begin
            model[bus.DM_Addr] = bus.M_W_Data;
        end
        #1;
    endtask

    task automatic sweep(input string tag);
        bus.Mem_Write = 1'b0;
        for (int a = 0; a < 64; a++) begin
            bus.DM_Addr = 6'(a);
            #1;
            check_eq(tag, bus.M_R_Data, model[a]);
        end
    endtask

    initial begin
        logic [5:0]  addr;
        logic [31:0] data;
        logic        we;
        logic        rst;

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 64; i++) model[i] = 32'h0;

        // Reset with a coincident write at address 7: the write must be lost.
        drive(1'b1, 1'b1, 6'd7, 32'h12345678);
        @(negedge clk_dm);
        tick();
        check_eq("rst_prio_addr7", bus.M_R_Data, 32'h0);
        rst_dm = 1'b1;
        sweep("rst_held_zero");
        @(negedge clk_dm);
        drive(1'b0, 1'b0, 6'd0, 32'h0);
        tick();

        for (int i = 0; i <= 30; i++) begin
            drive(1'b0, 1'b1, 6'(i), 32'h1 << i);
            tick();
            check_eq($sformatf("walk_wr_%0d", i), bus.M_R_Data, 32'h1 << i);
        end
        check_eq("walk_addr5_model", model[5], 32'h00000020);
        sweep("walk_sweep");
        for (int a = 31; a < 64; a++) begin
            bus.DM_Addr = 6'(a);
            #1;
            check_eq($sformatf("upper_zero_%0d", a), bus.M_R_Data, 32'h0);
        end

        drive(1'b0, 1'b0, 6'd3, 32'hDEADBEEF);
        tick();
        check_eq("no_we_addr3", bus.M_R_Data, 32'h00000008);

        drive(1'b0, 1'b1, 6'd63, 32'hFFFFFFFF);
        tick();
        drive(1'b0, 1'b1, 6'd0, 32'hA5A5A5A5);
        tick();
        bus.Mem_Write = 1'b0;
        bus.DM_Addr = 6'd63;
        #1;
        check_eq("edge_addr63", bus.M_R_Data, 32'hFFFFFFFF);
        bus.DM_Addr = 6'd0;
        #1;
        check_eq("edge_addr0", bus.M_R_Data, 32'hA5A5A5A5);

        // Random traffic with occasional mid-operation resets.
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 39) == 0);
            we   = 1'($urandom_range(0, 1));
            addr = 6'($urandom_range(0, 63));
            data = $urandom;
            drive(rst, we, addr, data);
            #1;
            check_eq("rnd_pre_edge", bus.M_R_Data, model[addr]);
            tick();
            check_eq("rnd_post_edge", bus.M_R_Data, model[addr]);
            addr = 6'($urandom_range(0, 63));
            bus.DM_Addr = addr;
            bus.M_W_Data = $urandom;
            #1;
            check_eq("rnd_async_read", bus.M_R_Data, model[addr]);
        end
        sweep("rnd_final_sweep");

        // Reset after traffic: contents gone, coincident write at 7 dropped.
        drive(1'b0, 1'b1, 6'd7, 32'hCAFEF00D);
        tick();
        drive(1'b1, 1'b1, 6'd7, 32'h12345678);
        tick();
        check_eq("late_rst_addr7", bus.M_R_Data, 32'h0);
        rst_dm = 1'b0;
        sweep("late_rst_sweep");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_ram
`default_nettype wire
